seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed hexadecimal display word and scans one digit per refresh slot. Each digit's nibble is decoded to an active-low segment pattern, with per-digit decimal point, blanking and optional leading-zero suppression. It sits between the CPU's display/debug register and the board's SEG/AN pins, replacing per-digit combinational decoders.

---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 114 +++++++++++
 tb/tb_seg7_scan_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-side signal bundle for the seven-segment scan driver.
// The master side owns the display word and the controls; the slave side returns SEG/AN.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank;
  logic                  lzb;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output en, load, data, dp_in, blank, lzb,
    input  seg, an
  );

  modport slave (
    input  en, load, data, dp_in, blank, lzb,
    output seg, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: latches a hex word, scans one digit
// per slot, and drives active-low segments/anodes with dp, blanking and leading-zero suppression.
module seg7_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 1
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] data_reg;
  logic [DIGITS-1:0]   dp_reg;
  logic [DIGITS-1:0]   blank_reg;
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   an_reg, an_next;
  logic                tick;
  logic                dark;
  logic                zero_acc;
  logic [DIGITS-1:0]   zero_above;
  logic [6:0]          dec [DIGITS];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h18;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dec
      assign dec[gi] = hex7(data_reg[4*gi +: 4]);
    end
  endgenerate

  assign tick = bus.en && (cnt_reg == CNT_W'(SCAN_DIV - 1));

  // zero_above[i]: nibbles i..DIGITS-1 of the shadow are all zero
  always_comb begin
    zero_above = '0;
    zero_acc   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (data_reg[4*i +: 4] == 4'h0);
      zero_above[i] = zero_acc;
    end
    dark = blank_reg[idx_reg] || (bus.lzb && (idx_reg != '0) && zero_above[idx_reg]);
  end

  always_comb begin
    cnt_next = cnt_reg;
    idx_next = idx_reg;
    if (bus.en) begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
    end
    if (tick) begin
      idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
  end

  // The dead cycle lands on the last count of each slot, so a slot is SCAN_DIV-1 lit + 1 dark.
  always_comb begin
    seg_next = 8'hFF;
    an_next  = '1;
    if (bus.en && !((GUARD != 0) && tick) && !dark) begin
      seg_next = {~dp_reg[idx_reg], dec[idx_reg]};
      an_next  = ~(DIGITS'(1) << idx_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      dp_reg    <= '0;
      blank_reg <= '0;
      seg_reg   <= 8'hFF;
      an_reg    <= '1;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      seg_reg <= seg_next;
      an_reg  <= an_next;
      if (bus.load) begin
        data_reg  <= bus.data;
        dp_reg    <= bus.dp_in;
        blank_reg <= bus.blank;
      end
    end
  end

  assign bus.seg = seg_reg;
  assign bus.an  = an_reg;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-position model predicts SEG/AN each cycle,
// a separate monitor compares the DUT outputs against the queued predictions.
module tb_seg7_scan_driver;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int DW       = 4 * DIGITS;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .GUARD   (GUARD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Segment patterns (g..a, active-low) for hex digits 0..F
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: position within the frame plus the latched display word
  int              m_pos = 0;
  logic [DW-1:0]   m_data = '0;
  logic [DIGITS-1:0] m_dp = '0;
  logic [DIGITS-1:0] m_blank = '0;

  logic [7+DIGITS:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Predict the output produced by the coming clock edge, advance the model, then clock.
  task automatic step();
    logic [7:0]        es;
    logic [DIGITS-1:0] ea;
    int                d;
    bit                hi_zero;
    es = 8'hFF;
    ea = '1;
    if (rst) begin
      m_pos   = 0;
      m_data  = '0;
      m_dp    = '0;
      m_blank = '0;
    end else begin
      d = m_pos / SCAN_DIV;
      if (bus.en && !(GUARD != 0 && (m_pos % SCAN_DIV) == SCAN_DIV - 1)) begin
        hi_zero = 1'b1;
        for (int k = d; k < DIGITS; k++)
          if (((m_data >> (4 * k)) & 16'hF) != 0) hi_zero = 1'b0;
        if (!(m_blank[d] || (bus.lzb && d > 0 && hi_zero))) begin
          es = {~m_dp[d], tbl[(m_data >> (4 * d)) & 16'hF]};
          ea = '1;
          ea[d] = 1'b0;
        end
      end
      if (bus.en) m_pos = (m_pos + 1) % FRAME;
      if (bus.load) begin
        m_data  = bus.data;
        m_dp    = bus.dp_in;
        m_blank = bus.blank;
      end
    end
    exp_q.push_back({es, ea});
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [DW-1:0] d, input logic [DIGITS-1:0] dp,
                         input logic [DIGITS-1:0] bl);
    bus.load  = 1'b1;
    bus.data  = d;
    bus.dp_in = dp;
    bus.blank = bl;
    $display("load data=%h dp=%b blank=%b lzb=%0d pos=%0d", d, dp, bl, bus.lzb, m_pos);
    step();
    bus.load = 1'b0;
  endtask

  // Monitor: one comparison per clock once a prediction exists
  initial begin
    logic [7+DIGITS:0] e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.seg, bus.an} !== e) begin
          errors++;
          $display("FAIL scan cyc=%0d seg=%h an=%b required seg=%h an=%b",
                   cyc, bus.seg, bus.an, e[7+DIGITS:DIGITS], e[DIGITS-1:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0]     rd;
    logic [DIGITS-1:0] rdp, rbl;
    bus.en    = 1'b1;
    bus.load  = 1'b0;
    bus.data  = '0;
    bus.dp_in = '0;
    bus.blank = '0;
    bus.lzb   = 1'b0;
    rst       = 1'b1;

    $display("reset held 3 cycles with en=1");
    repeat (3) step();
    rst = 1'b0;

    do_load(16'h1A2F, 4'b0000, 4'b0000);
    repeat (2 * FRAME) step();

    do_load(16'h8888, 4'b0100, 4'b0001);
    repeat (FRAME + 4) step();

    bus.lzb = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    repeat (FRAME + 4) step();
    do_load(16'h0000, 4'b0000, 4'b0000);
    repeat (FRAME + 4) step();
    bus.lzb = 1'b0;

    do_load(16'h7C3E, 4'b1010, 4'b0000);
    for (int i = 0; i < 2 * FRAME && m_pos != 2 * SCAN_DIV + 1; i++) step();
    $display("freeze en=0 for 10 cycles at pos=%0d", m_pos);
    bus.en = 1'b0;
    repeat (10) step();
    bus.en = 1'b1;
    repeat (FRAME) step();

    for (int i = 0; i < 2 * FRAME && m_pos != 3 * SCAN_DIV + 1; i++) step();
    $display("mid-scan reset at pos=%0d", m_pos);
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_load(16'h4321, 4'b0000, 4'b0000);
    for (int i = 0; i < 2 * FRAME && (m_pos % SCAN_DIV) != SCAN_DIV - 1; i++) step();
    do_load(16'hDB96, 4'b0001, 4'b0000);
    repeat (FRAME + 2) step();

    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      bus.en  = ($urandom_range(0, 9) != 0);
      bus.lzb = ($urandom_range(0, 3) != 0) ? bus.lzb : ~bus.lzb;
      if (rst) $display("random reset at pos=%0d", m_pos);
      if ($urandom_range(0, 15) == 0) begin
        rd  = DW'($urandom);
        rd  = rd & (16'hFFFF >> (4 * $urandom_range(0, 4)));
        rdp = DIGITS'($urandom);
        rbl = ($urandom_range(0, 2) == 0) ? DIGITS'($urandom) : '0;
        do_load(rd, rdp, rbl);
      end else begin
        step();
      end
    end
    rst    = 1'b0;
    bus.en = 1'b1;
    step();

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
